gpio_ctrl_bridge: RTL and testbench

Parametrised bridge between a 32-bit AXI GPIO core and a set of HLS accelerator block-level handshakes (ap_start/ap_ready/ap_done/ap_continue/ap_idle) plus soft-reset and mode lines. It replaces the purely combinational GPIO-to-control mapping. Level-sensitive ap_start is generated from GPIO edges, and one-cycle ap_done pulses are latched so software polling cannot miss them. Reset requests are stretched into timed pulses with busy readback.

---
 rtl/gpio_ctrl_pkg.sv | 46 ++++
 rtl/gpio_ctrl_channel.sv | 98 +++++++++
 rtl/gpio_ctrl_bridge.sv | 140 ++++++++++++++
 tb/tb_gpio_ctrl_bridge.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/gpio_ctrl_pkg.sv
// gpio_ctrl_pkg
// Shared definitions for the GPIO-to-HLS control bridge: channel state
// encoding, per-channel bit offsets inside a 4-bit channel slot, and the
// positions of the reset and misc fields, which sit just above the
// channel slots and therefore move with NUM_CH.
package gpio_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } ch_state_e;

    // Width of one channel slot in both GPIO directions
    localparam int CH_STRIDE    = 4;

    // GPIO_O offsets inside a channel slot
    localparam int OFS_START    = 0;
    localparam int OFS_COMPLETE = 1;

    // GPIO_I offsets inside a channel slot
    localparam int OFS_BUSY     = 0;
    localparam int OFS_ERR      = 1;
    localparam int OFS_DONE     = 2;
    localparam int OFS_IDLE     = 3;

    // Reset request k (GPIO_O) and pulse-active k (GPIO_I)
    function automatic int rst_req_bit(input int num_ch, input int k);
        return CH_STRIDE * num_ch + k;
    endfunction

    // rst_busy[k] readback (GPIO_I)
    function automatic int rst_busy_bit(input int num_ch, input int k);
        return CH_STRIDE * num_ch + 4 + k;
    endfunction

    function automatic int cache_bit(input int num_ch);
        return CH_STRIDE * num_ch + 8;
    endfunction

    function automatic int bram_bit(input int num_ch);
        return CH_STRIDE * num_ch + 9;
    endfunction

endpackage

// File: rtl/gpio_ctrl_channel.sv
// gpio_ctrl_channel
// One HLS block-level handshake controller plus its sticky status flags.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_start_rise        one-cycle software start request (edge already detected)
//   i_complete_rise     one-cycle software completion acknowledge
//   i_ready/i_done/i_idle  ap_ready / ap_done / ap_idle from the accelerator
//   o_start, o_continue ap_start (level) and ap_continue (one-cycle pulse)
//   o_busy, o_err, o_done, o_idle  registered status for GPIO_I
module gpio_ctrl_channel
    import gpio_ctrl_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start_rise,
    input  logic i_complete_rise,
    input  logic i_ready,
    input  logic i_done,
    input  logic i_idle,
    output logic o_start,
    output logic o_continue,
    output logic o_busy,
    output logic o_err,
    output logic o_done,
    output logic o_idle
);

    ch_state_e r_state;
    ch_state_e w_next_state;
    logic      w_start_nxt;
    logic      w_continue_nxt;
    logic      w_busy_nxt;
    logic      w_err_nxt;
    logic      w_done_nxt;

    // State and registered outputs; reset aborts any handshake in flight
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            o_start    <= 1'b0;
            o_continue <= 1'b0;
            o_busy     <= 1'b0;
            o_err      <= 1'b0;
            o_done     <= 1'b0;
            o_idle     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            o_start    <= w_start_nxt;
            o_continue <= w_continue_nxt;
            o_busy     <= w_busy_nxt;
            o_err      <= w_err_nxt;
            o_done     <= w_done_nxt;
            o_idle     <= i_idle;
        end
    end

    // Next-state logic; ready+done together skips RUN entirely
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start_rise) w_next_state = ST_START;
                else              w_next_state = ST_IDLE;
            end
            ST_START: begin
                if (i_ready && i_done) w_next_state = ST_DONE;
                else if (i_ready)      w_next_state = ST_RUN;
                else                   w_next_state = ST_START;
            end
            ST_RUN: begin
                if (i_done) w_next_state = ST_DONE;
                else        w_next_state = ST_RUN;
            end
            ST_DONE: begin
                if (i_complete_rise) w_next_state = ST_IDLE;
                else                 w_next_state = ST_DONE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; sets win over complete clears
    always_comb begin
        w_start_nxt    = (w_next_state == ST_START);
        w_busy_nxt     = (w_next_state != ST_IDLE);
        // Continue acknowledges any complete rise, even outside DONE
        w_continue_nxt = i_complete_rise;

        if (i_done)               w_done_nxt = 1'b1;
        else if (i_complete_rise) w_done_nxt = 1'b0;
        else                      w_done_nxt = o_done;

        if (i_start_rise && (r_state != ST_IDLE)) w_err_nxt = 1'b1;
        else if (i_complete_rise)                 w_err_nxt = 1'b0;
        else                                      w_err_nxt = o_err;
    end

endmodule

// File: rtl/gpio_ctrl_bridge.sv
// gpio_ctrl_bridge
// Bridges a 32-bit AXI GPIO core to NUM_CH HLS block-level handshakes,
// NUM_RST timed soft-reset pulses and two misc control lines.
// Ports:
//   ap_clk, ap_rst      clock, asynchronous active-high reset
//   GPIO_O / GPIO_T     software-written bits / tristate enables (unused)
//   GPIO_I              registered status readback; unmapped bits read 1
//   ch_*                per-channel ap_start/ap_continue/ap_ready/ap_done/ap_idle
//   rst_out, rst_busy   soft-reset pulses and downstream busy indications
//   cache_en, bram_sel  registered copies of their GPIO_O bits
module gpio_ctrl_bridge
    import gpio_ctrl_pkg::*;
#(
    parameter int NUM_CH           = 4,
    parameter int NUM_RST          = 3,
    parameter int RST_PULSE_CYCLES = 16,
    parameter int GPIO_W           = 32
)(
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [GPIO_W-1:0] GPIO_O,
    input  logic [GPIO_W-1:0] GPIO_T,
    output logic [GPIO_W-1:0] GPIO_I,
    output logic [NUM_CH-1:0] ch_start,
    output logic [NUM_CH-1:0] ch_continue,
    input  logic [NUM_CH-1:0] ch_ready,
    input  logic [NUM_CH-1:0] ch_done,
    input  logic [NUM_CH-1:0] ch_idle,
    output logic [NUM_RST-1:0] rst_out,
    input  logic [NUM_RST-1:0] rst_busy,
    output logic              cache_en,
    output logic              bram_sel
);

    localparam int CH_BITS = CH_STRIDE * NUM_CH;
    localparam int CNT_W   = $clog2(RST_PULSE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_PULSE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    if ((CH_BITS + 10 > GPIO_W) || (NUM_CH < 1) || (NUM_CH > 5) ||
        (NUM_RST < 1) || (NUM_RST > 4) || (RST_PULSE_CYCLES < 1)) begin : g_param_check
        $error("gpio_ctrl_bridge: illegal parameter combination");
    end

    logic [GPIO_W-1:0]  r_o_q;
    logic [GPIO_W-1:0]  w_rise;
    logic [NUM_RST-1:0] r_rst_busy;
    logic [NUM_CH-1:0]  w_ch_busy;
    logic [NUM_CH-1:0]  w_ch_err;
    logic [NUM_CH-1:0]  w_ch_done;
    logic [NUM_CH-1:0]  w_ch_idle;
    logic               w_unused;

    // o_q resets to ones so a bit held high across reset release cannot fire
    assign w_rise   = GPIO_O & ~r_o_q;
    assign w_unused = ^{GPIO_T, w_rise};

    // GPIO_O history, status input capture and misc control registers
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_o_q      <= {GPIO_W{1'b1}};
            r_rst_busy <= {NUM_RST{1'b0}};
            cache_en   <= 1'b0;
            bram_sel   <= 1'b0;
        end else begin
            r_o_q      <= GPIO_O;
            r_rst_busy <= rst_busy;
            cache_en   <= GPIO_O[cache_bit(NUM_CH)];
            bram_sel   <= GPIO_O[bram_bit(NUM_CH)];
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        gpio_ctrl_channel u_ch (
            .i_clk           (ap_clk),
            .i_rst           (ap_rst),
            .i_start_rise    (w_rise[CH_STRIDE*c + OFS_START]),
            .i_complete_rise (w_rise[CH_STRIDE*c + OFS_COMPLETE]),
            .i_ready         (ch_ready[c]),
            .i_done          (ch_done[c]),
            .i_idle          (ch_idle[c]),
            .o_start         (ch_start[c]),
            .o_continue      (ch_continue[c]),
            .o_busy          (w_ch_busy[c]),
            .o_err           (w_ch_err[c]),
            .o_done          (w_ch_done[c]),
            .o_idle          (w_ch_idle[c])
        );
    end

    for (genvar k = 0; k < NUM_RST; k++) begin : g_rst
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             r_pulse;

        // A new request reloads the counter, stretching an active pulse
        always_comb begin
            if (w_rise[rst_req_bit(NUM_CH, k)]) w_cnt_nxt = CNT_LOAD;
            else if (r_cnt != CNT_ZERO)         w_cnt_nxt = r_cnt - CNT_ONE;
            else                                w_cnt_nxt = r_cnt;
        end

        // Pulse counter and registered pulse output
        always_ff @(posedge ap_clk or posedge ap_rst) begin
            if (ap_rst) begin
                r_cnt   <= CNT_ZERO;
                r_pulse <= 1'b0;
            end else begin
                r_cnt   <= w_cnt_nxt;
                r_pulse <= (w_cnt_nxt != CNT_ZERO);
            end
        end

        assign rst_out[k] = r_pulse;
    end

    // GPIO_I is a pure rewiring of registers; unmapped bits are tied high
    for (genvar b = 0; b < GPIO_W; b++) begin : g_gpio_i
        if (b < CH_BITS) begin : g_chan
            if ((b % CH_STRIDE) == OFS_BUSY) begin : g_busy
                assign GPIO_I[b] = w_ch_busy[b / CH_STRIDE];
            end else if ((b % CH_STRIDE) == OFS_ERR) begin : g_err
                assign GPIO_I[b] = w_ch_err[b / CH_STRIDE];
            end else if ((b % CH_STRIDE) == OFS_DONE) begin : g_done
                assign GPIO_I[b] = w_ch_done[b / CH_STRIDE];
            end else begin : g_idle
                assign GPIO_I[b] = w_ch_idle[b / CH_STRIDE];
            end
        end else if (b < rst_req_bit(NUM_CH, NUM_RST)) begin : g_pulse
            assign GPIO_I[b] = rst_out[b - rst_req_bit(NUM_CH, 0)];
        end else if ((b >= rst_busy_bit(NUM_CH, 0)) &&
                     (b < rst_busy_bit(NUM_CH, NUM_RST))) begin : g_rbusy
            assign GPIO_I[b] = r_rst_busy[b - rst_busy_bit(NUM_CH, 0)];
        end else begin : g_unmapped
            assign GPIO_I[b] = 1'b1;
        end
    end

endmodule

// File: tb/tb_gpio_ctrl_bridge.sv
// tb_gpio_ctrl_bridge
// Directed bench for gpio_ctrl_bridge at default parameters. Expected
// values are pushed into a scoreboard queue when stimulus is applied and
// popped when the corresponding DUT output is sampled (#1 after posedge).
module tb_gpio_ctrl_bridge;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [31:0] GPIO_O;
    logic [31:0] GPIO_T;
    logic [31:0] GPIO_I;
    logic [3:0]  ch_start;
    logic [3:0]  ch_continue;
    logic [3:0]  ch_ready;
    logic [3:0]  ch_done;
    logic [3:0]  ch_idle;
    logic [2:0]  rst_out;
    logic [2:0]  rst_busy;
    logic        cache_en;
    logic        bram_sel;

    gpio_ctrl_bridge #(
        .NUM_CH(4), .NUM_RST(3), .RST_PULSE_CYCLES(16), .GPIO_W(32)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .GPIO_O      (GPIO_O),
        .GPIO_T      (GPIO_T),
        .GPIO_I      (GPIO_I),
        .ch_start    (ch_start),
        .ch_continue (ch_continue),
        .ch_ready    (ch_ready),
        .ch_done     (ch_done),
        .ch_idle     (ch_idle),
        .rst_out     (rst_out),
        .rst_busy    (rst_busy),
        .cache_en    (cache_en),
        .bram_sel    (bram_sel)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   hi_cnt;

    task automatic expect_val(input string tag, input logic [63:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL sb_empty observed=%0h required=queued_entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                fails++;
                $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        // ---------------- reset with start bit held high ----------------
        ap_rst = 1'b1; GPIO_O = 32'h0000_0001; GPIO_T = 32'h0000_0000;
        ch_ready = 4'h0; ch_done = 4'h0; ch_idle = 4'h0; rst_busy = 3'b000;
        step(); step();
        expect_val("reset_gpio_i", 64'hFF88_0000); check(GPIO_I);
        expect_val("reset_outs", 64'h0);
        check({ch_start, ch_continue, rst_out, cache_en, bram_sel});

        ap_rst = 1'b0; ch_idle = 4'hF;
        expect_val("held_bit_no_start", 64'h0);
        step(); check(ch_start);
        expect_val("idle_latency", 64'hFF88_8888); check(GPIO_I);
        expect_val("held_bit_no_start2", 64'h0);
        step(); check(ch_start);

        // clear then set: now a real rise, plus reset request 0
        GPIO_O = 32'h0000_0000; step();
        GPIO_O = 32'h0001_0001;
        expect_val("start_after_reset", 64'h1);
        step(); check(ch_start);
        expect_val("pulse0_started", 64'h1); check(rst_out);

        // asynchronous abort mid-START, no clock edge in between
        ap_rst = 1'b1; #1;
        expect_val("async_start_drop", 64'h0); check(ch_start);
        expect_val("async_rst_out_drop", 64'h0); check(rst_out);
        expect_val("async_gpio_i", 64'hFF88_0000); check(GPIO_I);
        expect_val("unmapped_ones", 64'h3F); check(GPIO_I[31:26]);
        GPIO_O = 32'h0000_0000;
        step(); step();
        ap_rst = 1'b0;
        step();

        // ---------------- channel 0 full handshake ----------------
        GPIO_O[0] = 1'b1;
        expect_val("ch0_start", 64'h1);
        step(); check(ch_start);
        expect_val("ch0_busy", 64'hFF88_8889); check(GPIO_I);
        ch_ready[0] = 1'b1;
        expect_val("ch0_start_held_until_ready", 64'h0);
        step(); check(ch_start);
        ch_ready[0] = 1'b0;
        ch_done[0] = 1'b1;
        expect_val("ch0_done_sticky", 64'hFF88_888D);
        step(); check(GPIO_I);
        ch_done[0] = 1'b0;
        expect_val("ch0_done_stays", 64'hFF88_888D);
        step(); check(GPIO_I);
        GPIO_O[1] = 1'b1;
        expect_val("ch0_continue", 64'h1);
        step(); check(ch_continue);
        expect_val("ch0_cleared", 64'hFF88_8888); check(GPIO_I);
        expect_val("ch0_continue_one_cycle", 64'h0);
        step(); check(ch_continue);

        // ---------------- channel 1 start rise while RUN ----------------
        GPIO_O[4] = 1'b1;
        expect_val("ch1_start", 64'h2);
        step(); check(ch_start);
        ch_ready[1] = 1'b1; step(); ch_ready[1] = 1'b0;
        GPIO_O[4] = 1'b0; step();
        GPIO_O[4] = 1'b1;
        expect_val("ch1_no_restart", 64'h0);
        step(); check(ch_start);
        expect_val("ch1_err_set", 64'hFF88_88B8); check(GPIO_I);
        ch_done[1] = 1'b1;
        expect_val("ch1_err_kept_done", 64'hFF88_88F8);
        step(); check(GPIO_I);
        ch_done[1] = 1'b0;
        GPIO_O[5] = 1'b1;
        expect_val("ch1_continue", 64'h2);
        step(); check(ch_continue);
        expect_val("ch1_err_cleared", 64'hFF88_8888); check(GPIO_I);

        // ---------------- channel 2 ready+done together, then done vs complete ----------------
        GPIO_O[8] = 1'b1; step();
        ch_ready[2] = 1'b1; ch_done[2] = 1'b1;
        expect_val("ch2_start_to_done", 64'hFF88_8D88);
        step(); check(GPIO_I);
        ch_ready[2] = 1'b0;
        GPIO_O[9] = 1'b1;
        expect_val("ch2_set_wins", 64'hFF88_8C88);
        step(); check(GPIO_I);
        expect_val("ch2_continue", 64'h4); check(ch_continue);
        ch_done[2] = 1'b0;
        GPIO_O[8] = 1'b0; step();
        GPIO_O[8] = 1'b1;
        expect_val("ch2_back_in_idle", 64'h4);
        step(); check(ch_start);
        expect_val("ch2_no_err", 64'hFF88_8D88); check(GPIO_I);

        // ---------------- reset pulser 1 ----------------
        GPIO_O[17] = 1'b1; step();
        hi_cnt = int'(rst_out[1]);
        GPIO_O[17] = 1'b0;
        for (int i = 1; i < 60; i++) begin
            step();
            if (rst_out[1]) hi_cnt++;
            else break;
        end
        expect_val("pulse_len_16", 64'd16); check(64'(hi_cnt));

        GPIO_O[17] = 1'b1; step();
        hi_cnt = int'(rst_out[1]);
        for (int i = 1; i < 60; i++) begin
            GPIO_O[17] = (i == 10);
            step();
            if (rst_out[1]) hi_cnt++;
            else break;
        end
        GPIO_O[17] = 1'b0;
        expect_val("pulse_len_26", 64'd26); check(64'(hi_cnt));

        rst_busy = 3'b010;
        expect_val("rst_busy_not_yet", 64'h0); check(GPIO_I[21]);
        expect_val("rst_busy_follow", 64'h1);
        step(); check(GPIO_I[21]);
        rst_busy = 3'b000;
        expect_val("rst_busy_release", 64'h0);
        step(); check(GPIO_I[21]);

        // ---------------- misc registers ----------------
        GPIO_O[24] = 1'b1; GPIO_O[25] = 1'b1;
        expect_val("cache_bram", 64'h3);
        step(); check({cache_en, bram_sel});
        expect_val("unmapped_high", 64'h3F); check(GPIO_I[31:26]);

        tests++;
        assert (sb.size() === 0) else begin
            fails++;
            $error("FAIL sb_leftover observed=%0d required=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
